spiflash_responder: RTL
=======================

# spiflash_responder

Synthesizable single-IO SPI flash responder that replaces the external boot flash when the management SoC runs on an FPGA. It sits between the core's flash master pins (flash_csb, flash_clk, flash_io0_do, flash_io1_di) and a byte-wide synchronous memory (BRAM preloaded with the firmware image), answering read commands the way a serial NOR flash does. It oversamples the SPI pins in the core clock domain.

## Interface
- ADDR_WIDTH, 14: byte address width of the backing memory (image size 2^ADDR_WIDTH bytes).
- core_clk  in  1  system clock; all logic on its rising edge.
- core_rstn  in  1  asynchronous active-low reset.
- flash_csb  in  1  chip select from the flash master, active low.
- flash_clk  in  1  SPI clock from the master (mode 0, idle low).
- flash_io0  in  1  serial data from the master (MOSI).
- flash_io1  out  1  serial data to the master (MISO).
- flash_io1_oeb  out  1  output enable for flash_io1, active low.
- mem_en  out  1  one-cycle read strobe to the memory.
- mem_addr  out  ADDR_WIDTH  byte address to the memory.
- mem_rdata  in  8  memory data, valid the cycle after mem_en.
- powered_down  out  1  high while in deep power-down.

## Operation
- flash_csb, flash_clk, flash_io0 pass through 2-flop synchronizers; rising/falling edges of flash_clk are detected from the synchronized copy.
- States: IDLE, CMD, ADDR, DUMMY (macro only), DATA, IGNORE.
- IDLE: wait for synchronized csb low -> CMD, bit counter 0.
- CMD: sample io0 on each sclk rise, MSB first; after 8 bits decode:
  - 0x03 READ -> ADDR; 0xAB release power-down -> clear powered_down, IGNORE; 0xB9 -> set powered_down, IGNORE; 0x0B -> DUMMY path (macro only, else IGNORE); any other -> IGNORE.
  - While powered_down, every opcode except 0xAB -> IGNORE.
- ADDR: shift 24 bits MSB first; address = low ADDR_WIDTH bits (upper bits ignored). After 24th bit: mem_en pulse with mem_addr = address -> DATA (or DUMMY).
- DATA: flash_io1_oeb low; on each sclk fall drive next bit MSB first from the output shift register. When bit 7 of a byte is driven, fetch address+1 (mem_en pulse); load it before bit 0 of the next byte completes. Address increments mod 2^ADDR_WIDTH (wrap to 0 at top).
- IGNORE: discard bits until csb high.
- csb high in any state: return to IDLE within sync latency; flash_io1_oeb high, partial command/address discarded; powered_down persists.

## Timing
- Reset values: flash_io1=0, flash_io1_oeb=1, mem_en=0, mem_addr=0, powered_down=0, state IDLE.
- Input-to-action latency: 3 core_clk cycles (2 sync + 1 edge detect).
- flash_clk high and low phases each ≥ 6 core_clk cycles; faster clocks are unsupported.
- First data bit (bit 7 of byte at address) appears on flash_io1 within 3 cycles after the sclk fall following the 24th address rise; master samples on the next rise.
- mem_rdata captured exactly 1 cycle after mem_en; exactly one mem_en per byte delivered (+1 speculative prefetch at csb rise, harmless).
- Asynchronous reset mid-transfer clears all state immediately; outputs take reset values.

## Configuration
- FLASH_FAST_READ_EN defined: opcode 0x0B accepted; after address, 8 dummy sclk cycles (DUMMY state, io1 tri-stated) precede DATA; memory fetch is issued at end of address as for 0x03.
- Not defined: 0x0B treated as unknown -> IGNORE, io1 stays tri-stated, no mem_en.

## Test plan
- Memory byte[i] = i & 0xFF; READ 0x03, addr 0x000010, clock 4 bytes -> master receives 0x10,0x11,0x12,0x13; 4 mem_en pulses (plus ≤1 prefetch).
- ADDR_WIDTH=14, READ at 0x003FFE, 4 bytes -> 0xFE,0xFF,0x00,0x01 (wrap); address 0xFF3FFE gives identical data.
- 0xB9 then READ 0x000000 -> io1_oeb stays 1, no mem_en; then 0xAB, READ -> data 0x00; powered_down 1 -> 0.
- csb raised after 12 address bits, then fresh READ 0x000020 -> returns 0x20, no stale bits; oeb high within 3 cycles of csb rise.
- Opcode 0x9F -> no io1 drive, no mem_en; with FLASH_FAST_READ_EN, 0x0B addr 0x000005 + 8 dummy clocks -> 0x05,0x06.
- core_rstn low mid-DATA -> flash_io1_oeb=1, mem_en=0 immediately; after release, new READ 0x000000 returns 0x00.

Source files
------------

// File: rtl/spiflash_responder.sv
// -----------------------------------------------------------------------------
// spiflash_responder
//
// Single-IO SPI NOR flash responder. It stands in for the external boot flash
// when the management SoC runs on an FPGA. Read commands are served from a
// byte-wide synchronous memory, such as a BRAM preloaded with the firmware
// image. The SPI pins are oversampled in the core_clk domain.
//
// Optional feature macro: FLASH_FAST_READ_EN
//   When defined, FAST READ (0x0B) is accepted and 8 dummy clocks follow the
//   address. When undefined, 0x0B is treated as an unknown opcode.
//
// Ports:
//   core_clk       in   system clock; all logic runs on its rising edge
//   core_rstn      in   asynchronous active-low reset
//   flash_csb      in   chip select from the flash master, active low
//   flash_clk      in   SPI clock from the master (mode 0, idle low)
//   flash_io0      in   serial data from the master (MOSI)
//   flash_io1      out  serial data to the master (MISO)
//   flash_io1_oeb  out  output enable for flash_io1, active low
//   mem_en         out  one-cycle read strobe to the backing memory
//   mem_addr       out  byte address to the backing memory
//   mem_rdata      in   memory data, valid the cycle after mem_en
//   powered_down   out  high while in deep power-down
// -----------------------------------------------------------------------------
module spiflash_responder #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  core_clk,
  input  logic                  core_rstn,
  input  logic                  flash_csb,
  input  logic                  flash_clk,
  input  logic                  flash_io0,
  output logic                  flash_io1,
  output logic                  flash_io1_oeb,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  powered_down
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_e;

  // Pin synchronizers. Chip select resets to its idle (deasserted) level.
  logic [1:0] csb_sync_q;
  logic [1:0] clk_sync_q;
  logic [1:0] io0_sync_q;
  logic       clk_prev_q;

  state_e                state_q;
  logic [4:0]            bit_cnt_q;
  // Holds one bit fewer than the address. The incoming bit completes the
  // value, so the top bit is never shifted out unused.
  logic [ADDR_WIDTH-2:0] shift_q;
  logic [7:0]            out_sr_q;
  logic                  load_q;
  logic                  io1_q;
  logic                  oeb_q;
  logic                  mem_en_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  pd_q;
`ifdef FLASH_FAST_READ_EN
  logic                  fast_q;
`endif

  logic                  csb_s;
  logic                  io0_s;
  logic                  sclk_rise;
  logic                  sclk_fall;
  logic [7:0]            op_d;
  logic [ADDR_WIDTH-1:0] addr_d;

  assign csb_s     = csb_sync_q[1];
  assign io0_s     = io0_sync_q[1];
  assign sclk_rise =  clk_sync_q[1] & ~clk_prev_q;
  assign sclk_fall = ~clk_sync_q[1] &  clk_prev_q;
  // Each value includes the bit arriving on the current rise.
  assign op_d      = {shift_q[6:0], io0_s};
  assign addr_d    = {shift_q, io0_s};

  // NOTE: every register here is assigned with <= so that all state updates
  // take effect together at the clock edge, whatever order the statements are
  // written in. Blocking assignments would let later statements see values
  // that were only just updated in the same cycle.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      csb_sync_q <= 2'b11;
      clk_sync_q <= 2'b00;
      io0_sync_q <= 2'b00;
      clk_prev_q <= 1'b0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      out_sr_q   <= '0;
      load_q     <= 1'b0;
      io1_q      <= 1'b0;
      oeb_q      <= 1'b1;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      pd_q       <= 1'b0;
`ifdef FLASH_FAST_READ_EN
      fast_q     <= 1'b0;
`endif
    end else begin
      csb_sync_q <= {csb_sync_q[0], flash_csb};
      clk_sync_q <= {clk_sync_q[0], flash_clk};
      io0_sync_q <= {io0_sync_q[0], flash_io0};
      clk_prev_q <= clk_sync_q[1];

      // mem_en is a single-cycle strobe. Read data returns one cycle later.
      mem_en_q <= 1'b0;
      load_q   <= mem_en_q;
      if (load_q) out_sr_q <= mem_rdata;

      if (csb_s) begin
        // Deselect aborts any partial command. powered_down persists.
        state_q   <= ST_IDLE;
        oeb_q     <= 1'b1;
        io1_q     <= 1'b0;
        load_q    <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_q   <= ST_CMD;
            bit_cnt_q <= '0;
          end

          ST_CMD: if (sclk_rise) begin
            shift_q   <= addr_d[ADDR_WIDTH-2:0];
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_q <= '0;
              state_q   <= ST_IGNORE;
              if (op_d == 8'hAB) begin
                pd_q <= 1'b0;
              end else if (!pd_q) begin
                unique case (op_d)
                  8'h03: begin
                    state_q <= ST_ADDR;
`ifdef FLASH_FAST_READ_EN
                    fast_q  <= 1'b0;
`endif
                  end
`ifdef FLASH_FAST_READ_EN
                  8'h0B: begin
                    state_q <= ST_ADDR;
                    fast_q  <= 1'b1;
                  end
`endif
                  8'hB9:   pd_q <= 1'b1;
                  default: ;
                endcase
              end
            end
          end

          ST_ADDR: if (sclk_rise) begin
            shift_q   <= addr_d[ADDR_WIDTH-2:0];
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              // Only the low ADDR_WIDTH bits select a byte. Upper bits wrap.
              bit_cnt_q  <= '0;
              mem_addr_q <= addr_d;
              mem_en_q   <= 1'b1;
`ifdef FLASH_FAST_READ_EN
              if (fast_q) begin
                state_q <= ST_DUMMY;
              end else begin
                state_q <= ST_DATA;
                oeb_q   <= 1'b0;
              end
`else
              state_q <= ST_DATA;
              oeb_q   <= 1'b0;
`endif
            end
          end

          ST_DUMMY: if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_q <= '0;
              state_q   <= ST_DATA;
              oeb_q     <= 1'b0;
            end
          end

          ST_DATA: if (sclk_fall) begin
            io1_q     <= out_sr_q[7];
            out_sr_q  <= {out_sr_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              // The last bit of this byte is now on the wire. Fetch the next
              // byte so it is loaded before the following fall.
              bit_cnt_q  <= '0;
              mem_en_q   <= 1'b1;
              mem_addr_q <= mem_addr_q + 1'b1;
            end
          end

          ST_IGNORE: ;

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign flash_io1     = io1_q;
  assign flash_io1_oeb = oeb_q;
  assign mem_en        = mem_en_q;
  assign mem_addr      = mem_addr_q;
  assign powered_down  = pd_q;

endmodule
